// File: rtl/axis_channel_splitter_if.sv
// -----------------------------------------------------------------------------
// axis_channel_splitter_if
//
// Bundles the AXI-Stream signals of axis_channel_splitter:
//   s_axis_real_* / s_axis_imag_* : one complex input stream (tdata, tvalid,
//                                   tlast in; tready out of the splitter)
//   m_axis_real_* / m_axis_imag_* : CHANNELS broadcast output streams per path,
//                                   channel k at slice k (tdata, tkeep, tlast,
//                                   tvalid out of the splitter; tready in)
//
// Modports:
//   slave  : the splitter's view (consumes s_*, produces m_*)
//   master : the surrounding environment's view (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface axis_channel_splitter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int CHANNELS   = 4
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]            s_axis_real_tdata;
    logic                             s_axis_real_tvalid;
    logic                             s_axis_real_tlast;
    logic                             s_axis_real_tready;
    logic [DATA_WIDTH-1:0]            s_axis_imag_tdata;
    logic                             s_axis_imag_tvalid;
    logic                             s_axis_imag_tlast;
    logic                             s_axis_imag_tready;

    logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_real_tdata;
    logic [CHANNELS*KEEP_WIDTH-1:0]   m_axis_real_tkeep;
    logic [CHANNELS-1:0]              m_axis_real_tlast;
    logic [CHANNELS-1:0]              m_axis_real_tvalid;
    logic [CHANNELS-1:0]              m_axis_real_tready;
    logic [CHANNELS*DATA_WIDTH-1:0]   m_axis_imag_tdata;
    logic [CHANNELS*KEEP_WIDTH-1:0]   m_axis_imag_tkeep;
    logic [CHANNELS-1:0]              m_axis_imag_tlast;
    logic [CHANNELS-1:0]              m_axis_imag_tvalid;
    logic [CHANNELS-1:0]              m_axis_imag_tready;

    modport slave (
        input  s_axis_real_tdata, s_axis_real_tvalid, s_axis_real_tlast,
        output s_axis_real_tready,
        input  s_axis_imag_tdata, s_axis_imag_tvalid, s_axis_imag_tlast,
        output s_axis_imag_tready,
        output m_axis_real_tdata, m_axis_real_tkeep, m_axis_real_tlast, m_axis_real_tvalid,
        input  m_axis_real_tready,
        output m_axis_imag_tdata, m_axis_imag_tkeep, m_axis_imag_tlast, m_axis_imag_tvalid,
        input  m_axis_imag_tready
    );

    modport master (
        output s_axis_real_tdata, s_axis_real_tvalid, s_axis_real_tlast,
        input  s_axis_real_tready,
        output s_axis_imag_tdata, s_axis_imag_tvalid, s_axis_imag_tlast,
        input  s_axis_imag_tready,
        input  m_axis_real_tdata, m_axis_real_tkeep, m_axis_real_tlast, m_axis_real_tvalid,
        output m_axis_real_tready,
        input  m_axis_imag_tdata, m_axis_imag_tkeep, m_axis_imag_tlast, m_axis_imag_tvalid,
        output m_axis_imag_tready
    );
endinterface

// File: rtl/axis_channel_splitter.sv
// -----------------------------------------------------------------------------
// axis_channel_splitter
//
// Broadcasts each complex input beat (real + imag stream) to CHANNELS output
// pairs (index 0=ch00, 1=ch01, 2=ch20, 3=ch21). Every one of the 2*CHANNELS
// output streams owns a one-beat holding slot; the input is accepted only
// when every slot is empty or being drained this cycle, so all channels stay
// in lock-step. One cycle latency, one beat per cycle when all sinks are ready.
//
// Ports:
//   clock          : rising-edge clock
//   resetn         : synchronous, active-low reset (also gates s_*_tready)
//   axis           : axis_channel_splitter_if.slave (s_axis_* in, m_axis_* out)
//   beat_count     : beats accepted in the current frame (0 after tlast beat),
//                    saturating at 16'hFFFF
//   tlast_mismatch : sticky, set when an accepted beat has real tlast != imag
//                    tlast; cleared only by reset
//
// Optional feature (macro AXIS_SPLIT_SCALE_EN): each loaded sample becomes
// (x + 2^(SHIFT-1)) >>> SHIFT, round-half-up, to undo the combiner's 4x gain.
// Without the macro samples pass bit-exact and SHIFT has no effect.
// -----------------------------------------------------------------------------
module axis_channel_splitter #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int CHANNELS     = 4,
    parameter int SHIFT        = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    axis_channel_splitter_if.slave  axis,
    output logic [15:0]             beat_count,
    output logic                    tlast_mismatch
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int SAMPLES    = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int BUS_WIDTH  = CHANNELS * DATA_WIDTH;
    localparam int KEEP_BUS   = CHANNELS * KEEP_WIDTH;

    if ((DATA_WIDTH % SAMPLE_WIDTH) != 0 || (DATA_WIDTH % 8) != 0 ||
        SHIFT < 0 || SHIFT >= SAMPLE_WIDTH) begin : g_bad_params
        $error("axis_channel_splitter: inconsistent DATA_WIDTH/SAMPLE_WIDTH/SHIFT");
    end

`ifdef AXIS_SPLIT_SCALE_EN
    // Half an output LSB; zero when SHIFT=0 so samples pass unchanged.
    localparam logic signed [SAMPLE_WIDTH:0] ROUND = (SAMPLE_WIDTH+1)'((2**SHIFT) / 2);
`endif

    // Per-beat sample conditioning applied on load.
    function automatic logic [DATA_WIDTH-1:0] scale_beat(input logic [DATA_WIDTH-1:0] beat);
`ifdef AXIS_SPLIT_SCALE_EN
        logic [DATA_WIDTH-1:0]         result;
        logic signed [SAMPLE_WIDTH:0]  sum;
        result = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            // Sign-extend by one bit so +max + ROUND cannot wrap.
            sum = $signed({beat[i*SAMPLE_WIDTH + SAMPLE_WIDTH - 1],
                           beat[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]}) + ROUND;
            sum = sum >>> SHIFT;
            result[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sum[SAMPLE_WIDTH-1:0];
        end
        return result;
`else
        return beat;
`endif
    endfunction

    logic [BUS_WIDTH-1:0] real_tdata_q,  real_tdata_d,  imag_tdata_q,  imag_tdata_d;
    logic [KEEP_BUS-1:0]  real_tkeep_q,  real_tkeep_d,  imag_tkeep_q,  imag_tkeep_d;
    logic [CHANNELS-1:0]  real_tlast_q,  real_tlast_d,  imag_tlast_q,  imag_tlast_d;
    logic [CHANNELS-1:0]  real_tvalid_q, real_tvalid_d, imag_tvalid_q, imag_tvalid_d;
    logic [15:0]          beat_count_q,  beat_count_d;
    logic                 tlast_mismatch_q, tlast_mismatch_d;
    logic                 can_load;
    logic                 accept;

    // Slot next-state: broadcast load on accept, otherwise per-slot drain.
    always_comb begin
        real_tdata_d     = real_tdata_q;
        imag_tdata_d     = imag_tdata_q;
        real_tkeep_d     = real_tkeep_q;
        imag_tkeep_d     = imag_tkeep_q;
        real_tlast_d     = real_tlast_q;
        imag_tlast_d     = imag_tlast_q;
        real_tvalid_d    = real_tvalid_q;
        imag_tvalid_d    = imag_tvalid_q;
        beat_count_d     = beat_count_q;
        tlast_mismatch_d = tlast_mismatch_q;

        // A slot is free if empty or handing its beat off this cycle.
        can_load = resetn
                 & (&(~real_tvalid_q | axis.m_axis_real_tready))
                 & (&(~imag_tvalid_q | axis.m_axis_imag_tready));
        accept   = can_load & axis.s_axis_real_tvalid & axis.s_axis_imag_tvalid;

        if (accept) begin
            // Load wins over a same-cycle drain, keeping the slot FULL.
            real_tdata_d  = {CHANNELS{scale_beat(axis.s_axis_real_tdata)}};
            imag_tdata_d  = {CHANNELS{scale_beat(axis.s_axis_imag_tdata)}};
            real_tkeep_d  = {KEEP_BUS{1'b1}};
            imag_tkeep_d  = {KEEP_BUS{1'b1}};
            real_tlast_d  = {CHANNELS{axis.s_axis_real_tlast}};
            imag_tlast_d  = {CHANNELS{axis.s_axis_imag_tlast}};
            real_tvalid_d = {CHANNELS{1'b1}};
            imag_tvalid_d = {CHANNELS{1'b1}};

            if (axis.s_axis_real_tlast) begin
                beat_count_d = 16'd0;
            end else if (beat_count_q != 16'hFFFF) begin
                beat_count_d = beat_count_q + 16'd1;
            end else begin
                beat_count_d = beat_count_q;
            end

            if (axis.s_axis_real_tlast != axis.s_axis_imag_tlast) begin
                tlast_mismatch_d = 1'b1;
            end else begin
                tlast_mismatch_d = tlast_mismatch_q;
            end
        end else begin
            // Payload holds; only tvalid drops for slots that handed off.
            real_tvalid_d = real_tvalid_q & ~axis.m_axis_real_tready;
            imag_tvalid_d = imag_tvalid_q & ~axis.m_axis_imag_tready;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            real_tdata_q     <= '0;
            imag_tdata_q     <= '0;
            real_tkeep_q     <= '0;
            imag_tkeep_q     <= '0;
            real_tlast_q     <= '0;
            imag_tlast_q     <= '0;
            real_tvalid_q    <= '0;
            imag_tvalid_q    <= '0;
            beat_count_q     <= 16'd0;
            tlast_mismatch_q <= 1'b0;
        end else begin
            real_tdata_q     <= real_tdata_d;
            imag_tdata_q     <= imag_tdata_d;
            real_tkeep_q     <= real_tkeep_d;
            imag_tkeep_q     <= imag_tkeep_d;
            real_tlast_q     <= real_tlast_d;
            imag_tlast_q     <= imag_tlast_d;
            real_tvalid_q    <= real_tvalid_d;
            imag_tvalid_q    <= imag_tvalid_d;
            beat_count_q     <= beat_count_d;
            tlast_mismatch_q <= tlast_mismatch_d;
        end
    end

    assign axis.s_axis_real_tready = can_load;
    assign axis.s_axis_imag_tready = can_load;
    assign axis.m_axis_real_tdata  = real_tdata_q;
    assign axis.m_axis_real_tkeep  = real_tkeep_q;
    assign axis.m_axis_real_tlast  = real_tlast_q;
    assign axis.m_axis_real_tvalid = real_tvalid_q;
    assign axis.m_axis_imag_tdata  = imag_tdata_q;
    assign axis.m_axis_imag_tkeep  = imag_tkeep_q;
    assign axis.m_axis_imag_tlast  = imag_tlast_q;
    assign axis.m_axis_imag_tvalid = imag_tvalid_q;
    assign beat_count              = beat_count_q;
    assign tlast_mismatch          = tlast_mismatch_q;
endmodule
